flash_audio_streamer: RTL

FLASH_AUDIO_STREAMER -- requirements
Module: flash_audio_streamer

---
 rtl/flash_audio_streamer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/flash_audio_streamer.sv
// flash_audio_streamer: pulls samples from a flash reader and writes them as frames
// to an audio codec FIFO. Supports mono/stereo packing, normal/half/double playback
// speed and pause at frame boundaries; frame_count counts frames the codec accepted.
// Optional build macro FLASH_AUDIO_VOLUME_EN adds a 3-bit volume input that
// arithmetic-right-shifts every sample written to the codec.
module flash_audio_streamer #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 1,   // 1 = mono, 2 = stereo; other values are not supported
  parameter int CNT_W    = 24
) (
  input  logic              CLOCK_50,
  input  logic              resetb,
  input  logic [DATA_W-1:0] f_data,
  input  logic              f_valid,
  input  logic              f_done,
  output logic              f_next,
  input  logic              write_ready,
  output logic              write_s,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  input  logic [1:0]        speed,
  input  logic              pause,
`ifdef FLASH_AUDIO_VOLUME_EN
  input  logic [2:0]        volume,
`endif
  output logic              finished,
  output logic [CNT_W-1:0]  frame_count
);

  typedef enum logic [2:0] {S_FETCH, S_ACK, S_WAIT_WR, S_SEND, S_DONE} state_t;

  localparam logic [1:0] SPD_HALF   = 2'b01;
  localparam logic [1:0] SPD_DOUBLE = 2'b10;

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_left;        // latched frame, left slot
  logic [DATA_W-1:0] r_right;       // latched frame, right slot
  logic              r_slot;        // 1 once the left word of a stereo frame is held
  logic [1:0]        r_speed;       // speed captured with the first word of the frame
  logic              r_toggle;      // double mode: 1 -> current frame is dropped
  logic              r_repeat;      // half mode: first write of the frame already done
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_wd_left;
  logic [DATA_W-1:0] r_wd_right;

  logic              w_accept;
  logic              w_ack_done;
  logic              w_frame_full;
  logic              w_discard;
  logic              w_send_done;
  logic              w_repeat_write;
  logic [DATA_W-1:0] w_out_left;
  logic [DATA_W-1:0] w_out_right;

  // f_done wins over f_valid, and pause only blocks new words, never the exit to DONE
  assign w_accept       = (r_state == S_FETCH) && !f_done && !pause && f_valid;
  assign w_ack_done     = (r_state == S_ACK) && !f_valid;
  // the word just latched completes the frame (always true for mono)
  assign w_frame_full   = (CHANNELS == 1) || r_slot;
  assign w_discard      = (r_speed == SPD_DOUBLE) && r_toggle;
  assign w_send_done    = (r_state == S_SEND) && !write_ready;
  assign w_repeat_write = (r_speed == SPD_HALF) && !r_repeat;

`ifdef FLASH_AUDIO_VOLUME_EN
  logic [2:0] r_volume;

  assign w_out_left  = $signed(r_left) >>> r_volume;
  assign w_out_right = $signed(r_right) >>> r_volume;
`else
  assign w_out_left  = r_left;
  assign w_out_right = r_right;
`endif

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetb) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!resetb) r_state <= S_FETCH;
    else         r_state <= w_next_state;
  end

  // Next-state decode
  always_comb begin
    // NOTE: default first so no path through the case leaves the signal unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (f_done)        w_next_state = S_DONE;
        else if (w_accept) w_next_state = S_ACK;
      end
      S_ACK: begin
        if (!f_valid) begin
          if (!w_frame_full || w_discard) w_next_state = S_FETCH;
          else                            w_next_state = S_WAIT_WR;
        end
      end
      S_WAIT_WR: begin
        if (write_ready) w_next_state = S_SEND;
      end
      S_SEND: begin
        if (!write_ready) w_next_state = w_repeat_write ? S_WAIT_WR : S_FETCH;
      end
      S_DONE:  w_next_state = S_DONE;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Moore outputs: handshakes are pure state decodes, so f_next and write_s are exclusive
  always_comb begin
    f_next          = (r_state == S_ACK);
    write_s         = (r_state == S_SEND);
    finished        = (r_state == S_DONE);
    writedata_left  = r_wd_left;
    writedata_right = r_wd_right;
    frame_count     = r_count;
  end

  // Frame datapath: word latching, speed/toggle bookkeeping, codec data and frame counter
  always_ff @(posedge CLOCK_50 or negedge resetb) begin
    if (!resetb) begin
      r_left     <= '0;
      r_right    <= '0;
      r_slot     <= 1'b0;
      r_speed    <= 2'b00;
      r_toggle   <= 1'b0;
      r_repeat   <= 1'b0;
      r_count    <= '0;
      r_wd_left  <= '0;
      r_wd_right <= '0;
`ifdef FLASH_AUDIO_VOLUME_EN
      r_volume   <= 3'd0;
`endif
    end else begin
      if (w_accept) begin
        if (!r_slot) begin
          r_left  <= f_data;
          r_speed <= speed;
`ifdef FLASH_AUDIO_VOLUME_EN
          r_volume <= volume;
`endif
        end
        if (w_frame_full) r_right <= f_data;
      end

      if (w_ack_done) begin
        if (w_frame_full) begin
          r_slot <= 1'b0;
          if (r_speed == SPD_DOUBLE) r_toggle <= !r_toggle;
        end else begin
          r_slot <= 1'b1;
        end
      end

      if ((r_state == S_WAIT_WR) && write_ready) begin
        r_wd_left  <= w_out_left;
        r_wd_right <= w_out_right;
      end

      if (w_send_done) begin
        if (r_count != '1) r_count <= r_count + 1'b1;
        r_repeat <= w_repeat_write;
      end
    end
  end

endmodule
